// File: rtl/midi_tx_pkg.sv
// Shared constants, state types and message-length helper for the MIDI OUT
// transmitter. A MIDI event on the synth bus is {status, data1, data2}.
package midi_tx_pkg;

  localparam int MIDI_BYTES        = 24;
  localparam int MIDI_CLKS_PER_BIT = 3146;  // 98.304 MHz / 31250, rounded

  // Channel-voice status bytes for channel 0 (OR in the channel number).
  localparam logic [7:0] NOTE_OFF    = 8'h80;
  localparam logic [7:0] NOTE_ON     = 8'h90;
  localparam logic [7:0] CC          = 8'hB0;
  localparam logic [7:0] PROG_CHANGE = 8'hC0;
  localparam logic [7:0] PITCH_BEND  = 8'hE0;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DROP
  } msg_state_e;

  // Bytes on the wire for a status (including the status byte itself);
  // 0 means the event is not a transmittable channel-voice message.
  function automatic logic [1:0] midi_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status[7]) begin
      case (status[7:4])
        4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
        4'hC, 4'hD:                   len = 2'd2;
        default:                      len = 2'd0;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_tx_uart.sv
// uart_tx_byte: serializes one 8N1 byte, LSB first, CLKS_PER_BIT cycles per bit.
// A new byte offered while the stop bit ends starts immediately, so bytes run
// back to back with no idle gap.
//   clk_in    system clock
//   rst_in    async active-high reset (line returns high at once)
//   byte_in   byte to send, taken when valid_in && ready_out
//   valid_in  byte_in is valid
//   ready_out idle, or last cycle of the stop bit
//   tx_out    registered serial line, idle high
//
//   state   | meaning
//   U_IDLE  | line high, waiting for a byte
//   U_START | start bit (low)
//   U_DATA  | 8 data bits, bit_q counts them
//   U_STOP  | stop bit (high)
module uart_tx_byte
  import midi_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             bit_done;

  // Baud timer counts down; a bit ends when it reaches zero.
  assign bit_done = (cnt_q == '0);
  assign tx_out   = tx_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= U_IDLE;
      cnt_q   <= CNT_RELOAD;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_done ? CNT_RELOAD : cnt_q - 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    ready_out = 1'b0;
    case (state_q)
      U_IDLE: begin
        ready_out = 1'b1;
        cnt_d     = CNT_RELOAD;
        if (valid_in) begin
          state_d = U_START;
          shreg_d = byte_in;
          tx_d    = 1'b0;
        end
      end
      U_START: begin
        if (bit_done) begin
          state_d = U_DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      U_DATA: begin
        if (bit_done) begin
          if (bit_q == 3'd7) begin
            state_d = U_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      U_STOP: begin
        if (bit_done) begin
          ready_out = 1'b1;
          if (valid_in) begin
            state_d = U_START;
            shreg_d = byte_in;
            tx_d    = 1'b0;
          end else begin
            state_d = U_IDLE;
          end
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

endmodule

// File: rtl/midi_tx.sv
// midi_tx: turns 24-bit channel-voice events into 2- or 3-byte MIDI messages
// on the MIDI OUT line, with optional running-status compression.
//   clk_in          system clock
//   rst_in          async active-high reset
//   event_in        {status, data1, data2}, sampled on accept
//   event_valid_in  event_in is valid
//   event_ready_out high in IDLE; accept = valid && ready at a rising edge
//   tx_out          MIDI OUT serial line, idle high
//   busy_out        a message is on the wire
//
//   state   | meaning
//   ST_IDLE | ready for an event
//   ST_SEND | message bytes being fed to the byte serializer
//   ST_DROP | one-cycle turnaround after a non-transmittable event
module midi_tx
  import midi_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = MIDI_CLKS_PER_BIT,
  parameter int RUNNING_STATUS = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [MIDI_BYTES-1:0] event_in,
  input  logic                  event_valid_in,
  output logic                  event_ready_out,
  output logic                  tx_out,
  output logic                  busy_out
);

  msg_state_e  state_q, state_d;
  logic [15:0] msg_q, msg_d;          // pending bytes, next one in [7:0]
  logic [1:0]  rem_q, rem_d;          // bytes still to hand to the serializer
  logic [7:0]  last_status_q, last_status_d;
  logic        last_valid_q, last_valid_d;  // 0 = no running status

  logic [7:0]  status, data1, data2, u_byte;
  logic [1:0]  len;
  logic        skip, u_valid, u_ready;

  assign status = event_in[23:16];
  assign data1  = event_in[15:8] & 8'h7F;
  assign data2  = event_in[7:0] & 8'h7F;
  assign len    = midi_len(status);
  assign skip   = (RUNNING_STATUS != 0) && last_valid_q && (status == last_status_q);

  assign event_ready_out = (state_q == ST_IDLE);
  assign busy_out        = (state_q == ST_SEND);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      msg_q         <= 16'h0000;
      rem_q         <= 2'd0;
      last_status_q <= 8'h00;
      last_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      msg_q         <= msg_d;
      rem_q         <= rem_d;
      last_status_q <= last_status_d;
      last_valid_q  <= last_valid_d;
    end
  end

  // The first byte goes to the serializer in the accept cycle itself, so the
  // start bit appears on the line one cycle after accept.
  always_comb begin
    state_d       = state_q;
    msg_d         = msg_q;
    rem_d         = rem_q;
    last_status_d = last_status_q;
    last_valid_d  = last_valid_q;
    u_valid       = 1'b0;
    u_byte        = msg_q[7:0];
    case (state_q)
      ST_IDLE: begin
        if (event_valid_in) begin
          if (len == 2'd0) begin
            state_d = ST_DROP;
            if (status[7:4] == 4'hF) last_valid_d = 1'b0;
          end else begin
            state_d = ST_SEND;
            u_valid = 1'b1;
            if (skip) begin
              u_byte = data1;
              msg_d  = {8'h00, data2};
              rem_d  = (len == 2'd3) ? 2'd1 : 2'd0;
            end else begin
              u_byte        = status;
              msg_d         = {data2, data1};
              rem_d         = len - 2'd1;
              last_status_d = status;
              last_valid_d  = 1'b1;
            end
          end
        end
      end
      ST_SEND: begin
        u_valid = (rem_q != 2'd0);
        if (u_ready) begin
          if (u_valid) begin
            msg_d = msg_q >> 8;
            rem_d = rem_q - 2'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .byte_in  (u_byte),
    .valid_in (u_valid),
    .ready_out(u_ready),
    .tx_out   (tx_out)
  );

endmodule

// File: tb/tb_midi_tx.sv
module tb_midi_tx;
  localparam int CPB  = 16;
  localparam int BYTE = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] ev [2];
  logic [1:0]  vld;
  logic [1:0]  rdy_w, tx_w, busy_w;
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1)) dut_rs (
    .clk_in(clk), .rst_in(rst), .event_in(ev[0]), .event_valid_in(vld[0]),
    .event_ready_out(rdy_w[0]), .tx_out(tx_w[0]), .busy_out(busy_w[0]));

  midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(0)) dut_nrs (
    .clk_in(clk), .rst_in(rst), .event_in(ev[1]), .event_valid_in(vld[1]),
    .event_ready_out(rdy_w[1]), .tx_out(tx_w[1]), .busy_out(busy_w[1]));

  // UART monitor: detects the start bit, samples each bit at mid-bit.
  logic [7:0] mon_byte  [2][$];
  int         mon_start [2][$];
  int         mon_bad_stop [2];

  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial begin
      logic [7:0] b;
      bit         abort, stop_bad;
      int         s;
      forever begin
        @(negedge clk);
        if (!rst && tx_w[g] === 1'b0) begin
          s = cyc; abort = 0; stop_bad = 0; b = '0;
          for (int t = 1; t <= 152; t++) begin
            @(negedge clk);
            if (rst) begin abort = 1; break; end
            if (t == 8 && tx_w[g] !== 1'b0) abort = 1;
            if (t >= 24 && t <= 136 && (t - 8) % 16 == 0) b[(t - 8) / 16 - 1] = tx_w[g];
            if (t == 152 && tx_w[g] !== 1'b1) stop_bad = 1;
          end
          if (!abort) begin
            mon_byte[g].push_back(b);
            mon_start[g].push_back(s);
            if (stop_bad) mon_bad_stop[g]++;
          end
        end
      end
    end
  end

  // Reference model: message bytes from the MIDI rules, per DUT.
  logic [7:0]  m_last [2];
  bit          m_lv [2];
  int          exp_n;
  logic [23:0] exp_bytes;

  function automatic void model(input int k, input logic [23:0] e);
    logic [7:0] st;
    bit         rs;
    st = e[23:16];
    rs = (k == 0);
    exp_n = 0; exp_bytes = '0;
    if (st < 8'h80) return;
    if (st >= 8'hF0) begin m_lv[k] = 0; return; end
    if (!(rs && m_lv[k] && m_last[k] == st)) begin
      exp_bytes = {exp_bytes[15:0], st}; exp_n++;
      m_last[k] = st; m_lv[k] = 1;
    end
    exp_bytes = {exp_bytes[15:0], e[15:8] % 8'd128}; exp_n++;
    if (st / 16 != 12 && st / 16 != 13) begin
      exp_bytes = {exp_bytes[15:0], e[7:0] % 8'd128}; exp_n++;
    end
  endfunction

  // Observations from the last send_ev call.
  int          obs_n, obs_acc, obs_done, obs_first, obs_span, obs_bad_stop;
  logic [23:0] obs_bytes;
  logic        obs_busy_mid, obs_busy_end;

  // Must be called at a negedge. Offers event e to DUT k after gap cycles.
  task automatic send_ev(input int k, input logic [23:0] e, input int gap, input bit wait_done);
    int n;
    repeat (gap) @(negedge clk);
    mon_byte[k].delete(); mon_start[k].delete(); mon_bad_stop[k] = 0;
    ev[k] = e; vld[k] = 1'b1;
    n = 0;
    while (rdy_w[k] !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    @(negedge clk);
    vld[k] = 1'b0;
    obs_acc = cyc; obs_busy_mid = busy_w[k];
    if (wait_done) begin
      n = 0;
      while (rdy_w[k] !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
      obs_done = cyc; obs_busy_end = busy_w[k];
      obs_n = mon_byte[k].size(); obs_bytes = '0;
      foreach (mon_byte[k][i]) obs_bytes = {obs_bytes[15:0], mon_byte[k][i]};
      obs_first = (obs_n > 0) ? mon_start[k][0] : -1;
      obs_span  = (obs_n > 0) ? mon_start[k][obs_n-1] - mon_start[k][0] : 0;
      obs_bad_stop = mon_bad_stop[k];
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      tests++; if (tx_w[k] !== 1'b1) begin failed++; $display("FAIL reset_tx dut%0d got %b want 1", k, tx_w[k]); end
      tests++; if (rdy_w[k] !== 1'b1) begin failed++; $display("FAIL reset_ready dut%0d got %b want 1", k, rdy_w[k]); end
      tests++; if (busy_w[k] !== 1'b0) begin failed++; $display("FAIL reset_busy dut%0d got %b want 0", k, busy_w[k]); end
    end
  endtask

  task automatic test_note_on;
    model(1, 24'h903C64); send_ev(1, 24'h903C64, 1, 1);
    tests++; if (obs_n != 3 || obs_bytes !== 24'h903C64) begin failed++; $display("FAIL note_on_nrs bytes got %0d:%h want 3:903c64", obs_n, obs_bytes); end
    model(0, 24'h903C64); send_ev(0, 24'h903C64, 1, 1);
    tests++; if (obs_n != 3 || obs_bytes !== 24'h903C64) begin failed++; $display("FAIL note_on bytes got %0d:%h want 3:903c64", obs_n, obs_bytes); end
    tests++; if (obs_first != obs_acc) begin failed++; $display("FAIL note_on start got %0d want %0d", obs_first, obs_acc); end
    tests++; if (obs_span != 2 * BYTE) begin failed++; $display("FAIL note_on byte_spacing got %0d want %0d", obs_span, 2 * BYTE); end
    tests++; if (obs_done - obs_acc != 3 * BYTE) begin failed++; $display("FAIL note_on ready_rise got %0d want %0d", obs_done - obs_acc, 3 * BYTE); end
    tests++; if (obs_busy_mid !== 1'b1 || obs_busy_end !== 1'b0) begin failed++; $display("FAIL note_on busy got %b/%b want 1/0", obs_busy_mid, obs_busy_end); end
    tests++; if (obs_bad_stop != 0) begin failed++; $display("FAIL note_on stop_bits got %0d bad want 0", obs_bad_stop); end
  endtask

  task automatic test_back_to_back;
    int prev_done;
    prev_done = obs_done;
    model(0, 24'h903E50); send_ev(0, 24'h903E50, 0, 1);
    tests++; if (obs_acc != prev_done + 1) begin failed++; $display("FAIL b2b accept got %0d want %0d", obs_acc, prev_done + 1); end
    tests++; if (obs_n != 2 || obs_bytes !== 24'h003E50) begin failed++; $display("FAIL running_status bytes got %0d:%h want 2:3e50", obs_n, obs_bytes); end
    tests++; if (obs_done - obs_acc != 2 * BYTE) begin failed++; $display("FAIL running_status ready_rise got %0d want %0d", obs_done - obs_acc, 2 * BYTE); end
    model(1, 24'h903E50); send_ev(1, 24'h903E50, 0, 1);
    tests++; if (obs_n != 3 || obs_bytes !== 24'h903E50) begin failed++; $display("FAIL no_running_status bytes got %0d:%h want 3:903e50", obs_n, obs_bytes); end
  endtask

  task automatic test_two_byte;
    model(0, 24'hC005FF); send_ev(0, 24'hC005FF, 1, 1);
    tests++; if (obs_n != 2 || obs_bytes !== 24'h00C005) begin failed++; $display("FAIL prog_change bytes got %0d:%h want 2:c005", obs_n, obs_bytes); end
    tests++; if (obs_done - obs_acc != 2 * BYTE) begin failed++; $display("FAIL prog_change ready_rise got %0d want %0d", obs_done - obs_acc, 2 * BYTE); end
  endtask

  task automatic test_dropped;
    model(0, 24'h903C64); send_ev(0, 24'h903C64, 1, 1);
    model(0, 24'h3C6400); send_ev(0, 24'h3C6400, 1, 1);
    tests++; if (obs_n != 0) begin failed++; $display("FAIL drop_nostatus bytes got %0d want 0", obs_n); end
    tests++; if (obs_done - obs_acc != 1 || obs_busy_mid !== 1'b0) begin failed++; $display("FAIL drop_nostatus ready_low got %0d busy %b want 1 busy 0", obs_done - obs_acc, obs_busy_mid); end
    model(0, 24'h903C64); send_ev(0, 24'h903C64, 1, 1);
    tests++; if (obs_n != 2 || obs_bytes !== 24'h003C64) begin failed++; $display("FAIL drop_keeps_status bytes got %0d:%h want 2:3c64", obs_n, obs_bytes); end
    model(0, 24'hF80000); send_ev(0, 24'hF80000, 0, 1);
    tests++; if (obs_n != 0 || obs_done - obs_acc != 1) begin failed++; $display("FAIL drop_system got %0d bytes ready_low %0d want 0/1", obs_n, obs_done - obs_acc); end
    model(0, 24'h903C64); send_ev(0, 24'h903C64, 0, 1);
    tests++; if (obs_n != 3 || obs_bytes !== 24'h903C64) begin failed++; $display("FAIL status_cleared bytes got %0d:%h want 3:903c64", obs_n, obs_bytes); end
  endtask

  task automatic test_mask;
    model(0, 24'hB0C1FF); send_ev(0, 24'hB0C1FF, 1, 1);
    tests++; if (obs_n != 3 || obs_bytes !== 24'hB0417F) begin failed++; $display("FAIL data_mask bytes got %0d:%h want 3:b0417f", obs_n, obs_bytes); end
  endtask

  task automatic test_reset_mid;
    model(0, 24'h903C64); send_ev(0, 24'h903C64, 1, 0);
    repeat (BYTE + 2 * CPB + CPB / 2) @(negedge clk);
    tests++; if (tx_w[0] !== 1'b0) begin failed++; $display("FAIL pre_reset_line got %b want 0", tx_w[0]); end
    rst = 1'b1;
    #1;
    tests++; if (tx_w[0] !== 1'b1) begin failed++; $display("FAIL async_reset_tx got %b want 1", tx_w[0]); end
    tests++; if (rdy_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin failed++; $display("FAIL async_reset_hs got ready %b busy %b want 1/0", rdy_w[0], busy_w[0]); end
    @(negedge clk);
    rst = 1'b0;
    m_lv[0] = 0; m_lv[1] = 0;
    model(0, 24'h903C64); send_ev(0, 24'h903C64, 1, 1);
    tests++; if (obs_n != 3 || obs_bytes !== 24'h903C64) begin failed++; $display("FAIL after_reset bytes got %0d:%h want 3:903c64", obs_n, obs_bytes); end
  endtask

  task automatic test_random;
    logic [3:0]  hi_tab [7];
    logic [7:0]  st;
    logic [23:0] e;
    int          k, sel, want_ready;
    hi_tab = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    for (int i = 0; i < 40; i++) begin
      k   = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel <= 6)      st = {hi_tab[sel], 4'($urandom_range(0, 1))};
      else if (sel == 7) st = 8'($urandom_range(8'hF0, 8'hFF));
      else if (sel == 8) st = 8'($urandom_range(0, 8'h7F));
      else               st = m_lv[k] ? m_last[k] : 8'h90;
      e = {st, 16'($urandom)};
      model(k, e);
      send_ev(k, e, $urandom_range(0, 2), 1);
      want_ready = (exp_n == 0) ? 1 : exp_n * BYTE;
      tests++; if (obs_n != exp_n || obs_bytes !== exp_bytes) begin failed++; $display("FAIL rand%0d bytes ev %h dut%0d got %0d:%h want %0d:%h", i, e, k, obs_n, obs_bytes, exp_n, exp_bytes); end
      tests++; if (obs_done - obs_acc != want_ready) begin failed++; $display("FAIL rand%0d ready_rise ev %h got %0d want %0d", i, e, obs_done - obs_acc, want_ready); end
      tests++; if (obs_busy_mid !== (exp_n != 0)) begin failed++; $display("FAIL rand%0d busy ev %h got %b want %b", i, e, obs_busy_mid, exp_n != 0); end
      if (exp_n > 0) begin
        tests++; if (obs_first != obs_acc || obs_bad_stop != 0) begin failed++; $display("FAIL rand%0d framing start %0d want %0d bad_stop %0d", i, obs_first, obs_acc, obs_bad_stop); end
      end
    end
  endtask

  initial begin
    ev[0] = '0; ev[1] = '0; vld = '0;
    m_lv[0] = 0; m_lv[1] = 0; m_last[0] = '0; m_last[1] = '0;
    mon_bad_stop[0] = 0; mon_bad_stop[1] = 0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_note_on;
    test_back_to_back;
    test_two_byte;
    test_dropped;
    test_mask;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
